// File: rtl/count_seq_monitor_if.sv
// Sample/control and status bundle between a counter stream source and count_seq_monitor.
interface count_seq_monitor_if;
   logic       in_valid;
   logic [3:0] count_in;
   logic       clr_err;
   logic       dir;
   logic       locked;
   logic       rev;
   logic       err;
   logic [7:0] step_cnt;
   logic [7:0] err_cnt;

   modport master (
      output in_valid, count_in, clr_err,
      input  dir, locked, rev, err, step_cnt, err_cnt
   );

   modport slave (
      input  in_valid, count_in, clr_err,
      output dir, locked, rev, err, step_cnt, err_cnt
   );
endinterface

// File: rtl/count_seq_monitor.sv
// Decodes a sampled 4-bit up/down count stream into direction, run length and illegal-step errors.
//
// state | meaning
// IDLE  | after reset, waiting for the first sample to seed prev
// ACQ   | waiting for the first legal +/-1 step; jumps and holds tolerated
// TRACK | locked; counting steps, flagging reversals and illegal jumps
// FAULT | illegal step seen; waiting for clr_err, samples only refresh prev
module count_seq_monitor (
   input  logic                 clk,
   input  logic                 rst_n,
   count_seq_monitor_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACQ   = 2'd1,
      TRACK = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t     r_state;
   logic [3:0] r_prev;
   logic       r_dir;
   logic       r_locked;
   logic       r_rev;
   logic       r_err;
   logic [7:0] r_step_cnt;
   logic [7:0] r_err_cnt;

   logic [3:0] w_delta;
   logic       w_up;
   logic       w_dn;
   logic       w_hold;
   logic       w_with_dir;

   // Modulo-16 difference makes 15->0 an up step and 0->15 a down step.
   assign w_delta    = bus.count_in - r_prev;
   assign w_up       = (w_delta == 4'd1);
   assign w_dn       = (w_delta == 4'd15);
   assign w_hold     = (w_delta == 4'd0);
   assign w_with_dir = r_dir ? w_dn : w_up;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_prev     <= 4'd0;
         r_dir      <= 1'b0;
         r_locked   <= 1'b0;
         r_rev      <= 1'b0;
         r_err      <= 1'b0;
         r_step_cnt <= 8'd0;
         r_err_cnt  <= 8'd0;
      end else begin
         r_rev <= 1'b0;
         if (bus.in_valid) begin
            r_prev <= bus.count_in;
         end
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_state <= ACQ;
               end
            end
            ACQ: begin
               if (bus.in_valid && (w_up || w_dn)) begin
                  r_dir      <= w_dn;
                  r_step_cnt <= 8'd1;
                  r_locked   <= 1'b1;
                  r_state    <= TRACK;
               end
            end
            TRACK: begin
               if (bus.in_valid && !w_hold) begin
                  if (w_with_dir) begin
                     if (r_step_cnt != 8'hFF) begin
                        r_step_cnt <= r_step_cnt + 8'd1;
                     end
                  end else if (w_up || w_dn) begin
                     r_dir      <= ~r_dir;
                     r_step_cnt <= 8'd1;
                     r_rev      <= 1'b1;
                  end else begin
                     // An error here beats a same-cycle clr_err, which only acts in FAULT.
                     r_err      <= 1'b1;
                     r_locked   <= 1'b0;
                     r_step_cnt <= 8'd0;
                     r_state    <= FAULT;
                     if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                     end
                  end
               end
            end
            FAULT: begin
               if (bus.clr_err) begin
                  r_err   <= 1'b0;
                  r_state <= ACQ;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.dir      = r_dir;
   assign bus.locked   = r_locked;
   assign bus.rev      = r_rev;
   assign bus.err      = r_err;
   assign bus.step_cnt = r_step_cnt;
   assign bus.err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed vector table plus hand sequences for saturation and async reset of count_seq_monitor.
module tb_count_seq_monitor;

   logic clk;
   logic rst_n;
   count_seq_monitor_if ifc ();

   count_seq_monitor dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Packed observation: {dir, locked, rev, err, step_cnt, err_cnt}
   typedef struct {
      bit         rst;
      bit         v;
      logic [3:0] c;
      bit         clr;
      logic [19:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rst, bit v, int c, bit clr,
                               bit dir, bit lk, bit rv, bit er, int st, int ec);
      vec_t t;
      t.rst = rst;
      t.v   = v;
      t.c   = 4'(c);
      t.clr = clr;
      t.exp = {dir, lk, rv, er, 8'(st), 8'(ec)};
      return t;
   endfunction

   function automatic logic [19:0] obs();
      return {ifc.dir, ifc.locked, ifc.rev, ifc.err, ifc.step_cnt, ifc.err_cnt};
   endfunction

   task automatic chk(string name, logic [19:0] act, logic [19:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got dir=%b lk=%b rev=%b err=%b step=%0d errc=%0d, want dir=%b lk=%b rev=%b err=%b step=%0d errc=%0d",
                  name, act[19], act[18], act[17], act[16], act[15:8], act[7:0],
                  exp[19], exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
      end
   endtask

   task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      ifc.in_valid = 1'b0;
      ifc.count_in = 4'd0;
      ifc.clr_err  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive one cycle at negedge, return 1 time unit after the capturing posedge.
   task automatic cyc(bit v, int c, bit clr);
      @(negedge clk);
      ifc.in_valid = v;
      ifc.count_in = 4'(c);
      ifc.clr_err  = clr;
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      ifc.clr_err  = 1'b0;
   endtask

   initial begin
      int p;
      bit hold_ok;

      // up sequence
      tbl.push_back(mk(1,1, 0,0, 0,0,0,0, 0,0));
      tbl.push_back(mk(0,1, 1,0, 0,1,0,0, 1,0));
      tbl.push_back(mk(0,1, 2,0, 0,1,0,0, 2,0));
      tbl.push_back(mk(0,1, 3,0, 0,1,0,0, 3,0));
      tbl.push_back(mk(0,1, 4,0, 0,1,0,0, 4,0));
      // down with wrap
      tbl.push_back(mk(1,1, 2,0, 0,0,0,0, 0,0));
      tbl.push_back(mk(0,1, 1,0, 1,1,0,0, 1,0));
      tbl.push_back(mk(0,1, 0,0, 1,1,0,0, 2,0));
      tbl.push_back(mk(0,1,15,0, 1,1,0,0, 3,0));
      tbl.push_back(mk(0,1,14,0, 1,1,0,0, 4,0));
      // reversal, then a gap and a second reversal back-to-back
      tbl.push_back(mk(1,1, 5,0, 0,0,0,0, 0,0));
      tbl.push_back(mk(0,1, 6,0, 0,1,0,0, 1,0));
      tbl.push_back(mk(0,1, 7,0, 0,1,0,0, 2,0));
      tbl.push_back(mk(0,1, 6,0, 1,1,1,0, 1,0));
      tbl.push_back(mk(0,1, 5,0, 1,1,0,0, 2,0));
      tbl.push_back(mk(0,0, 9,0, 1,1,0,0, 2,0));
      tbl.push_back(mk(0,1, 6,0, 0,1,1,0, 1,0));
      tbl.push_back(mk(0,1, 5,0, 1,1,1,0, 1,0));
      tbl.push_back(mk(0,1, 5,0, 1,1,0,0, 1,0));
      // illegal jump and recovery
      tbl.push_back(mk(1,1, 3,0, 0,0,0,0, 0,0));
      tbl.push_back(mk(0,1, 4,0, 0,1,0,0, 1,0));
      tbl.push_back(mk(0,1, 9,0, 0,0,0,1, 0,1));
      tbl.push_back(mk(0,1,10,1, 0,0,0,0, 0,1));
      tbl.push_back(mk(0,1,11,0, 0,1,0,0, 1,1));
      // clr_err in TRACK is ignored
      tbl.push_back(mk(0,1,12,1, 0,1,0,0, 2,1));
      // second fault; FAULT sample without clr keeps err; clr with no sample
      tbl.push_back(mk(0,1,14,0, 0,0,0,1, 0,2));
      tbl.push_back(mk(0,1,15,0, 0,0,0,1, 0,2));
      tbl.push_back(mk(0,0, 3,1, 0,0,0,0, 0,2));
      tbl.push_back(mk(0,1, 0,0, 0,1,0,0, 1,2));
      // error together with clr_err in TRACK: error wins
      tbl.push_back(mk(0,1, 5,1, 0,0,0,1, 0,3));
      tbl.push_back(mk(0,0, 0,1, 0,0,0,0, 0,3));
      tbl.push_back(mk(0,1, 4,0, 1,1,0,0, 1,3));

      do_reset();
      chk("reset", obs(), 20'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset();
         cyc(tbl[i].v, int'(tbl[i].c), tbl[i].clr);
         chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
      end

      // step saturation with interleaved holds
      do_reset();
      cyc(1, 0, 0);
      p = 0;
      hold_ok = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         p = (p + 1) % 16;
         cyc(1, p, 0);
         cyc(1, p, 0);
         if (ifc.locked !== 1'b1 || ifc.step_cnt !== 8'((i > 255) ? 255 : i)) hold_ok = 1'b0;
      end
      chk8("hold_lock_and_count", {7'd0, hold_ok}, 8'd1);
      chk8("step_sat", ifc.step_cnt, 8'd255);

      // error count saturation
      do_reset();
      cyc(1, 0, 0);
      p = 0;
      for (int i = 1; i <= 300; i++) begin
         cyc(1, (p + 1) % 16, 0);
         cyc(1, (p + 6) % 16, 0);
         if (i == 1) chk8("errc_first", ifc.err_cnt, 8'd1);
         cyc(0, 0, 1);
         p = (p + 6) % 16;
      end
      chk8("errc_sat", ifc.err_cnt, 8'd255);

      // async reset mid-TRACK
      do_reset();
      for (int i = 0; i <= 7; i++) cyc(1, i, 0);
      chk("pre_async", obs(), {1'b0, 1'b1, 1'b0, 1'b0, 8'd7, 8'd0});
      #1 rst_n = 1'b0;
      #1 chk("async_rst", obs(), 20'd0);
      rst_n = 1'b1;
      cyc(1, 8, 0);
      chk("post_rst_s8", obs(), 20'd0);
      cyc(1, 9, 0);
      chk("post_rst_s9", obs(), {1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, want finish");
      $fatal(1);
   end

endmodule
